clock_mode_controller: RTL and testbench
========================================

# clock_mode_controller

Parametrised successor to the clock's single-switch control unit. Debounces a mode switch and a set switch, sequences through a seconds-reset phase and NUM_FIELDS-1 field-setting phases, and emits per-field count enables, a step pulse with hold-to-auto-repeat, and display blink/dot controls. The block sits between the board switches and the time counter chain and display driver.

## Interface
- NUM_FIELDS, 3, number of counter fields (field 0 = seconds); must be ≥ 2
- DEBOUNCE_CYCLES, 65536, consecutive stable cycles required to accept a switch level
- REPEAT_DELAY, 25000000, cycles the set switch is held after the first step before auto-repeat starts
- REPEAT_PERIOD, 5000000, cycles between auto-repeat steps
- TIMEOUT_CYCLES, 500000000, idle cycles in a set phase before the block returns to IDLE
- i_Clock  in  1  single clock; all state updates on its rising edge
- i_Reset  in  1  synchronous, active-high reset
- i_Switch_Mode  in  1  raw, asynchronous mode switch, active-high
- i_Switch_Set  in  1  raw, asynchronous set switch, active-high
- o_Counters_Reset  out  1  clears the seconds field
- o_Counters_Enable_Increment  out  1  counters are in manual-step mode
- o_Counters_Step  out  1  one-cycle increment strobe for the enabled field
- o_Counters_Enable_Count  out  NUM_FIELDS  per-field count enable
- o_Display_Select  out  NUM_FIELDS  one-hot field to blink; all zeros means none
- o_Display_Enable_Dot  out  1  seconds dot enable

## Operation
- Each switch passes through a 2-flop synchronizer and then a debouncer. The debounced level flips once the synchronized value has differed from it for DEBOUNCE_CYCLES consecutive cycles. A rise event is a one-cycle pulse on a debounced 0→1 transition.
- FSM states: IDLE, RESET_SEC, and SET_FIELD with a field index k in 1..NUM_FIELDS-1.
  - IDLE: a mode rise event goes to RESET_SEC.
  - RESET_SEC: stays while debounced mode is high. A debounced mode low goes to SET_FIELD with k=1.
  - SET_FIELD(k): a mode rise event goes to SET_FIELD(k+1), or to IDLE when k=NUM_FIELDS-1. A timeout goes to IDLE.
- Outputs are a Moore decode of the state register:
  - IDLE: Reset=0, Enable_Increment=0, Enable_Count=all ones, Display_Select=0, Dot=1.
  - RESET_SEC: Reset=1, Enable_Increment=0, Enable_Count=0, Display_Select=0, Dot=0.
  - SET_FIELD(k): Reset=0, Enable_Increment=1, Enable_Count=one-hot bit k, Display_Select=one-hot bit k, Dot=0.
- o_Counters_Step is registered and is asserted only in SET_FIELD.
  - It pulses one cycle after each set rise event.
  - While debounced set stays high, it pulses again REPEAT_DELAY cycles after the first step, then every REPEAT_PERIOD cycles.
  - Releasing set stops the repeat immediately.
- Set events in IDLE or RESET_SEC are ignored. A set switch held across entry into SET_FIELD produces no step until it is released and pressed again.
- Timeout counter:
  - Cleared on entry into SET_FIELD and on any mode or set rise event.
  - Held at 0 outside SET_FIELD and while debounced set is high.
  - At TIMEOUT_CYCLES it forces IDLE.
- Simultaneous mode rise and set rise in SET_FIELD: the mode transition wins and no step is issued.
- i_Reset: all synchronizers, debouncers (level 0), counters, and the step register clear; state goes to IDLE. This holds mid-debounce or mid-repeat. Outputs equal the IDLE decode, with o_Counters_Step=0, on the cycle after the reset edge.

## Timing
- Edge numbering: edge 1 is the first edge that samples a new raw level.
- Debounced level changes at edge 2+DEBOUNCE_CYCLES.
- Rise event is asserted during the cycle after that edge.
- FSM state and decoded outputs change at edge 3+DEBOUNCE_CYCLES.
- o_Counters_Step is high during the cycle following edge 3+DEBOUNCE_CYCLES.
- A raw glitch shorter than DEBOUNCE_CYCLES cycles produces no event and resets the mismatch count.
- Auto-repeat uses a single counter. Consecutive repeat steps are exactly REPEAT_PERIOD cycles apart, rising edge to rising edge.

## Structure
- Package clock_ctrl_pkg holds:
  - typedef enum logic [1:0] ctrl_state_t {IDLE, RESET_SEC, SET_FIELD};
  - default constants for DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD, and TIMEOUT_CYCLES.
- Field index register width is $clog2(NUM_FIELDS).
- Counter widths are $clog2 of their respective limits plus 1.
- Sub-module switch_debouncer (synchronizer, debounce counter, level and rise outputs, DEBOUNCE_CYCLES parameter) is instantiated once per switch.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, NUM_FIELDS=3, REPEAT_DELAY=8, REPEAT_PERIOD=4, TIMEOUT_CYCLES=64.
1. Reset, then 10 idle cycles → Enable_Count=3'b111, Dot=1, all other outputs 0.
2. Mode high for 20 cycles, then low → RESET_SEC (Reset=1) appears 7 edges after press; SET_FIELD(1) (Enable_Count=3'b010, Display_Select=3'b010) appears 7 edges after release.
3. In SET_FIELD(1), a 3-cycle mode glitch → no state change; a clean press → SET_FIELD(2) (3'b100); another clean press → IDLE.
4. In SET_FIELD(1), hold set for 30 cycles → first step, then steps at +8, +12, +16, ... cycles; release → no further steps.
5. In SET_FIELD(2), no activity → IDLE exactly 64 cycles after entry; with set held, no timeout occurs.
6. Assert i_Reset during auto-repeat in SET_FIELD(2) → IDLE outputs and Step=0 on the next cycle; a set press after reset produces no step.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared controller state type and default timing constants for the clock mode controller.
package clock_ctrl_pkg;

   typedef enum logic [1:0] {IDLE, RESET_SEC, SET_FIELD} ctrl_state_t;

   localparam int DEFAULT_DEBOUNCE_CYCLES = 65536;
   localparam int DEFAULT_REPEAT_DELAY    = 25_000_000;
   localparam int DEFAULT_REPEAT_PERIOD   = 5_000_000;
   localparam int DEFAULT_TIMEOUT_CYCLES  = 500_000_000;

endpackage

// File: rtl/switch_debouncer.sv
// Raw switch -> 2-flop sync -> debounce; level settles 2+DEBOUNCE_CYCLES edges after a raw change,
// rise pulses one cycle alongside the new high level. No backpressure: free-running input.
module switch_debouncer
   import clock_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
   input  logic i_Clock,
   input  logic i_Reset,
   input  logic switch_raw,
   output logic level,
   output logic rise
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;

   logic [1:0]    sync_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;
   logic          rise_q;

   // Any cycle where the synchronized value matches the accepted level restarts the count.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[0], switch_raw};
         rise_q <= 1'b0;
         if (sync_q[1] != level_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
               level_q <= sync_q[1];
               rise_q  <= sync_q[1];
               cnt_q   <= '0;
            end else begin
               cnt_q <= cnt_q + CW'(1);
            end
         end else begin
            cnt_q <= '0;
         end
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/clock_mode_controller.sv
// Mode/set switch sequencer for the clock counters and display; outputs are a Moore decode of the
// state register, step is registered one cycle after a set rise. No backpressure: inputs are switches.
module clock_mode_controller
   import clock_ctrl_pkg::*;
#(
   parameter int NUM_FIELDS      = 3,
   parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
   parameter int REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD,
   parameter int TIMEOUT_CYCLES  = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  i_Clock,
   input  logic                  i_Reset,
   input  logic                  i_Switch_Mode,
   input  logic                  i_Switch_Set,
   output logic                  o_Counters_Reset,
   output logic                  o_Counters_Enable_Increment,
   output logic                  o_Counters_Step,
   output logic [NUM_FIELDS-1:0] o_Counters_Enable_Count,
   output logic [NUM_FIELDS-1:0] o_Display_Select,
   output logic                  o_Display_Enable_Dot
);

   localparam int KW      = $clog2(NUM_FIELDS);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = $clog2(RPT_MAX) + 1;
   localparam int TW      = $clog2(TIMEOUT_CYCLES) + 1;

   logic mode_level, mode_rise;
   logic set_level, set_rise;

   ctrl_state_t             state_q, state_d;
   logic [KW-1:0]           field_q, field_d;
   logic [NUM_FIELDS-1:0]   field_onehot;
   logic [TW-1:0]           tmo_cnt_q;
   logic [RW-1:0]           rep_cnt_q;
   logic                    rep_active_q;
   logic                    step_q;
   logic                    in_set;
   logic                    timeout;

   switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .switch_raw (i_Switch_Mode),
      .level      (mode_level),
      .rise       (mode_rise)
   );

   switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set_db (
      .i_Clock    (i_Clock),
      .i_Reset    (i_Reset),
      .switch_raw (i_Switch_Set),
      .level      (set_level),
      .rise       (set_rise)
   );

   assign in_set       = (state_q == SET_FIELD);
   assign field_onehot = NUM_FIELDS'(1) << field_q;
   assign timeout      = (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1)) && !set_level;

   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         state_q <= IDLE;
         field_q <= '0;
      end else begin
         state_q <= state_d;
         field_q <= field_d;
      end
   end

   always_comb begin
      state_d                     = state_q;
      field_d                     = field_q;
      o_Counters_Reset            = 1'b0;
      o_Counters_Enable_Increment = 1'b0;
      o_Counters_Enable_Count     = '0;
      o_Display_Select            = '0;
      o_Display_Enable_Dot        = 1'b0;
      case (state_q)
         IDLE: begin
            o_Counters_Enable_Count = '1;
            o_Display_Enable_Dot    = 1'b1;
            if (mode_rise) state_d = RESET_SEC;
         end
         RESET_SEC: begin
            o_Counters_Reset = 1'b1;
            if (!mode_level) begin
               state_d = SET_FIELD;
               field_d = KW'(1);
            end
         end
         SET_FIELD: begin
            o_Counters_Enable_Increment = 1'b1;
            o_Counters_Enable_Count     = field_onehot;
            o_Display_Select            = field_onehot;
            // A mode press outranks both the timeout and any coincident set press.
            if (mode_rise) begin
               if (field_q == KW'(NUM_FIELDS - 1)) state_d = IDLE;
               else                                field_d = field_q + KW'(1);
            end else if (timeout) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // One down-counter serves both the initial hold delay and the repeat period.
   always_ff @(posedge i_Clock) begin
      if (i_Reset) begin
         tmo_cnt_q    <= '0;
         rep_cnt_q    <= '0;
         rep_active_q <= 1'b0;
         step_q       <= 1'b0;
      end else begin
         step_q <= 1'b0;

         if (!in_set || set_level || mode_rise) tmo_cnt_q <= '0;
         else                                   tmo_cnt_q <= tmo_cnt_q + TW'(1);

         if (!in_set || !set_level || mode_rise) begin
            rep_active_q <= 1'b0;
         end else if (set_rise) begin
            step_q       <= 1'b1;
            rep_active_q <= 1'b1;
            rep_cnt_q    <= RW'(REPEAT_DELAY - 1);
         end else if (rep_active_q) begin
            if (rep_cnt_q == '0) begin
               step_q    <= 1'b1;
               rep_cnt_q <= RW'(REPEAT_PERIOD - 1);
            end else begin
               rep_cnt_q <= rep_cnt_q - RW'(1);
            end
         end
      end
   end

   assign o_Counters_Step = step_q;

endmodule

// File: tb/tb_clock_mode_controller.sv
// Directed + randomized bench for clock_mode_controller against a cycle-indexed behavioural model.
module tb_clock_mode_controller;

   localparam int NF   = 3;
   localparam int D    = 4;
   localparam int RD   = 8;
   localparam int RP   = 4;
   localparam int T    = 64;
   localparam int MAXE = 8192;
   localparam int VW   = 2 * NF + 4;

   localparam logic [VW-1:0] IDLE_VEC = {3'b000, {NF{1'b1}}, {NF{1'b0}}, 1'b1};

   logic          clk = 1'b0;
   logic          rst;
   logic          sw_mode;
   logic          sw_set;
   logic          o_reset, o_inc, o_step, o_dot;
   logic [NF-1:0] o_count, o_sel;
   logic [VW-1:0] obs_vec;

   int tests = 0;
   int fails = 0;
   int edge_n = 0;

   always #5 clk = ~clk;

   clock_mode_controller #(
      .NUM_FIELDS      (NF),
      .DEBOUNCE_CYCLES (D),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP),
      .TIMEOUT_CYCLES  (T)
   ) dut (
      .i_Clock                     (clk),
      .i_Reset                     (rst),
      .i_Switch_Mode               (sw_mode),
      .i_Switch_Set                (sw_set),
      .o_Counters_Reset            (o_reset),
      .o_Counters_Enable_Increment (o_inc),
      .o_Counters_Step             (o_step),
      .o_Counters_Enable_Count     (o_count),
      .o_Display_Select            (o_sel),
      .o_Display_Enable_Dot        (o_dot)
   );

   assign obs_vec = {o_reset, o_inc, o_step, o_count, o_sel, o_dot};

   // Model: raw input history per edge; phase 0 = idle, 1 = seconds reset, k+1 = setting field k.
   bit hist_m [MAXE];
   bit hist_s [MAXE];
   int last_rst = -1000;
   bit m_lvl_m, m_lvl_s, m_rise_m, m_rise_s, m_step, m_armed;
   int m_phase, m_clear, m_first;

   function automatic bit raw_at(bit which, int e);
      if (e < 1 || e <= last_rst || e >= MAXE) return 1'b0;
      return which ? hist_s[e] : hist_m[e];
   endfunction

   // The accepted level flips once the last D synchronized samples all disagree with it.
   function automatic bit flips(bit which, bit lvl, int n);
      for (int i = 2; i <= D + 1; i++)
         if (raw_at(which, n - i) == lvl) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [VW-1:0] decode(int phase, bit step);
      logic [NF-1:0] oh;
      oh = '0;
      if (phase == 0) return {1'b0, 1'b0, step, {NF{1'b1}}, {NF{1'b0}}, 1'b1};
      if (phase == 1) return {1'b1, 1'b0, step, {NF{1'b0}}, {NF{1'b0}}, 1'b0};
      oh[phase-1] = 1'b1;
      return {1'b0, 1'b1, step, oh, oh, 1'b0};
   endfunction

   task automatic model_edge();
      bit nlm, nls, nstep, narmed, in_set;
      int nphase, nclear, nfirst;
      if (edge_n < MAXE) begin
         hist_m[edge_n] = sw_mode;
         hist_s[edge_n] = sw_set;
      end
      if (rst) begin
         last_rst = edge_n;
         {m_lvl_m, m_lvl_s, m_rise_m, m_rise_s, m_step, m_armed} = '0;
         m_phase = 0;
         m_clear = edge_n;
         return;
      end
      in_set = (m_phase >= 2);
      nphase = m_phase;
      if (m_phase == 0) begin
         if (m_rise_m) nphase = 1;
      end else if (m_phase == 1) begin
         if (!m_lvl_m) nphase = 2;
      end else if (m_rise_m) begin
         nphase = (m_phase - 1 == NF - 1) ? 0 : m_phase + 1;
      end else if (!m_lvl_s && (edge_n - m_clear == T)) begin
         nphase = 0;
      end
      nclear = (!in_set || m_lvl_s || m_rise_m) ? edge_n : m_clear;
      nstep  = 1'b0;
      narmed = m_armed;
      nfirst = m_first;
      if (!in_set || !m_lvl_s || m_rise_m) begin
         narmed = 1'b0;
      end else if (m_rise_s) begin
         nstep  = 1'b1;
         narmed = 1'b1;
         nfirst = edge_n;
      end else if (m_armed && (edge_n - m_first >= RD) && ((edge_n - m_first - RD) % RP == 0)) begin
         nstep = 1'b1;
      end
      nlm = flips(1'b0, m_lvl_m, edge_n) ? ~m_lvl_m : m_lvl_m;
      nls = flips(1'b1, m_lvl_s, edge_n) ? ~m_lvl_s : m_lvl_s;
      m_rise_m = !m_lvl_m && nlm;
      m_rise_s = !m_lvl_s && nls;
      m_lvl_m  = nlm;
      m_lvl_s  = nls;
      m_phase  = nphase;
      m_clear  = nclear;
      m_step   = nstep;
      m_armed  = narmed;
      m_first  = nfirst;
   endtask

   task automatic tick();
      logic [VW-1:0] exp_vec;
      @(posedge clk);
      edge_n++;
      model_edge();
      #1;
      exp_vec = decode(m_phase, m_step);
      tests++;
      assert (obs_vec === exp_vec)
      else begin
         fails++;
         $error("FAIL model_cycle edge=%0d observed=%b expected=%b", edge_n, obs_vec, exp_vec);
      end
   endtask

   task automatic check(string tag, int obs, int exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic press_mode();
      int hold;
      hold = $urandom_range(D + 3, D + 10);
      sw_mode = 1'b1;
      repeat (hold) tick();
      sw_mode = 1'b0;
      repeat (hold) tick();
   endtask

   initial begin
      int g, p, w, entry, exp_n, any_step, r;
      int steps[$];
      sw_mode = 1'b0;
      sw_set  = 1'b0;
      rst     = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset and idle outputs
      repeat (10) tick();
      check("idle_after_reset", int'(obs_vec), int'(IDLE_VEC));

      // Mode press -> seconds reset, release -> field 1
      sw_mode = 1'b1;
      repeat (6) tick();
      check("resetsec_early", int'(o_reset), 0);
      tick();
      check("resetsec_at_7", int'(o_reset), 1);
      repeat (13) tick();
      sw_mode = 1'b0;
      repeat (6) tick();
      check("sf1_early", int'(o_count), 0);
      tick();
      check("sf1_count_at_7", int'(o_count), 2);
      check("sf1_select", int'(o_sel), 2);
      check("sf1_inc", int'(o_inc), 1);

      // Short glitch ignored, clean presses advance then wrap to idle
      g = $urandom_range(1, D - 1);
      sw_mode = 1'b1;
      repeat (g) tick();
      sw_mode = 1'b0;
      repeat (12) tick();
      check("glitch_no_change", int'(o_count), 2);
      press_mode();
      check("sf2_after_press", int'(o_count), 4);
      press_mode();
      check("idle_after_last", int'(o_count), 7);

      // Auto-repeat in field 1
      press_mode();
      check("sf1_reentry", int'(o_count), 2);
      p = edge_n;
      sw_set = 1'b1;
      repeat (30) begin
         tick();
         if (o_step) steps.push_back(edge_n);
      end
      sw_set = 1'b0;
      repeat (20) begin
         tick();
         if (o_step) steps.push_back(edge_n);
      end
      exp_n = 1;
      for (int e = p + D + 3 + RD; e <= p + 30 + D + 2; e += RP) exp_n++;
      check("step_count", steps.size(), exp_n);
      if (steps.size() >= 3) begin
         check("first_step_latency", steps[0] - p, D + 3);
         check("repeat_delay", steps[1] - steps[0], RD);
         check("repeat_period", steps[2] - steps[1], RP);
      end else begin
         check("too_few_steps", steps.size(), 3);
      end

      // Timeout from field 2
      sw_mode = 1'b1;
      w = 0;
      while (o_count != 3'b100 && w < 20) begin
         tick();
         w++;
      end
      entry = edge_n;
      check("sf2_entry", int'(o_count), 4);
      sw_mode = 1'b0;
      w = 0;
      while (o_count != 3'b111 && w < 200) begin
         tick();
         w++;
      end
      check("timeout_exact", edge_n - entry, T);

      // No timeout while set is held
      press_mode();
      press_mode();
      check("sf2_again", int'(o_count), 4);
      sw_set = 1'b1;
      repeat (100) tick();
      check("no_timeout_set_held", int'(o_count), 4);

      // Reset mid-repeat, later set press ignored in idle
      rst = 1'b1;
      tick();
      check("reset_mid_repeat", int'(obs_vec), int'(IDLE_VEC));
      rst = 1'b0;
      any_step = 0;
      repeat (15) begin tick(); if (o_step) any_step = 1; end
      sw_set = 1'b0;
      repeat (12) begin tick(); if (o_step) any_step = 1; end
      sw_set = 1'b1;
      repeat (20) begin tick(); if (o_step) any_step = 1; end
      sw_set = 1'b0;
      check("no_step_after_reset", any_step, 0);
      check("idle_after_reset_press", int'(o_count), 7);

      // Randomized soak against the model
      repeat (160) begin
         r = $urandom_range(0, 99);
         if (r < 3) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
         end else begin
            sw_mode = ($urandom_range(0, 3) == 0);
            sw_set  = ($urandom_range(0, 2) == 0);
            repeat ($urandom_range(1, 16)) tick();
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
